// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the CPU (C) and loader (L) ports.
// It allows one access in flight and returns read data after a fixed RD_LATENCY.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int NPORT = 2;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RD_DONE} state_t;

    // Port index 0 is the CPU, index 1 is the loader.
    logic [NPORT-1:0]  req;
    logic [NPORT-1:0]  we;
    logic [ADDR_W-1:0] addr  [NPORT];
    logic [DATA_W-1:0] wdata [NPORT];

    assign req      = {l_req, c_req};
    assign we       = {l_we, c_we};
    assign addr[0]  = c_addr;
    assign addr[1]  = l_addr;
    assign wdata[0] = c_wdata;
    assign wdata[1] = l_wdata;

    state_t            state_reg;
    logic              owner_reg;
    logic              last_owner_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [NPORT-1:0]  gnt_reg;
    logic [NPORT-1:0]  rvalid_reg;
    logic [DATA_W-1:0] rdata_reg [NPORT];
    logic              winner_next;

    // On a tie the port that did not own the previous access wins.
    always_comb begin
        winner_next = req[1];
        if (&req) begin
            winner_next = ~last_owner_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            cnt_reg        <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            gnt_reg        <= '0;
            rvalid_reg     <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
        end else begin
            gnt_reg    <= '0;
            rvalid_reg <= '0;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE, RD_DONE: begin
                    if (|req) begin
                        owner_reg            <= winner_next;
                        mem_en_reg           <= 1'b1;
                        mem_we_reg           <= we[winner_next];
                        mem_addr_reg         <= addr[winner_next];
                        mem_wdata_reg        <= wdata[winner_next];
                        gnt_reg[winner_next] <= 1'b1;
                        state_reg            <= ACCESS;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    last_owner_reg <= owner_reg;
                    if (mem_we_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_reg == LAT) begin
                        rdata_reg[owner_reg]  <= mem_rdata;
                        rvalid_reg[owner_reg] <= 1'b1;
                        state_reg             <= RD_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign c_gnt     = gnt_reg[0];
    assign l_gnt     = gnt_reg[1];
    assign c_rvalid  = rvalid_reg[0];
    assign l_rvalid  = rvalid_reg[1];
    assign c_rdata   = rdata_reg[0];
    assign l_rdata   = rdata_reg[1];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
